ssdec_mux: RTL
==============

// Module: ssdec_mux
// PURPOSE
//  Parametrised multi-digit seven-segment display driver for the stopwatch display path.
//  Accepts a binary count, converts it to BCD sequentially (shift-add-3), then
//  time-multiplexes the digits onto one shared segment bus with a one-hot digit select.
//  Replaces per-digit combinational decoders; any value 0..10^DIGITS-1 is shown exactly.
// PARAMETERS
//  WIDTH     8  width of binary input value
//  DIGITS    3  number of decimal digits driven (1..8)
//  SCAN_DIV  4  clock cycles each digit stays selected (>=1)
// PORTS
//  clk        in   1           system clock, all state on rising edge
//  rst        in   1           synchronous reset, active-high
//  enable     in   1           display enable; 0 blanks seg and digit_sel
//  load       in   1           request: convert value (accepted when ready=1)
//  value      in   WIDTH       binary value to display
//  ready      out  1           converter idle, load will be accepted
//  overflow   out  1           latched: last accepted value >= 10^DIGITS
//  seg        out  7           segments {g,f,e,d,c,b,a}, 1 = lit, registered
//  digit_sel  out  DIGITS      one-hot active digit, bit 0 = units, registered
// BEHAVIOUR
//  Clocking/reset: single clock clk; rst synchronous, active-high. Reset values:
//   FSM=IDLE, ready=1, overflow=0, display BCD reg=all 0, scan idx=0, divider=0,
//   seg=7'b0000000, digit_sel=0. rst mid-conversion aborts it; display shows all 0s.
//  FSM IDLE: ready=1. load&ready -> capture value, overflow_nxt=(value>=10^DIGITS), go CONV.
//  FSM CONV: ready=0; WIDTH iterations, one per cycle: add 3 to each BCD nibble >=5,
//   then shift {bcd,bin} left 1. After WIDTH-th iteration -> IDLE; on that same edge
//   display BCD reg and overflow update atomically. load while ready=0 is ignored (no queue).
//  Latency: accept edge -> display reg updated WIDTH cycles later; seg reflects new
//   digit on the next scan slot edge (<=1 further cycle for current slot).
//  Overflow: if overflow=1 every digit shows dash 7'b1000000 (BCD reg contents ignored).
//  Scan: divider counts 0..SCAN_DIV-1; at wrap idx increments, DIGITS-1 wraps to 0.
//   Scan runs regardless of enable and FSM state.
//  Output regs each cycle: enable=1 -> digit_sel=1<<idx, seg=decode(bcd[idx]);
//   enable=0 -> seg=0, digit_sel=0. So outputs lag idx/bcd by 1 cycle.
//  Decode: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101
//   6=1111101 7=0000111 8=1111111 9=1101111; nibble >9 (unreachable) -> 0000000.
//  Width rule: BCD reg is 4*DIGITS bits; carries out of top nibble during CONV are
//   discarded (only relevant when overflow=1, where digits are not displayed).
// CONFIGURATION
//  SSDEC_MUX_LZB_EN defined: leading-zero blanking - digit k>0 outputs seg=0 (digit_sel
//   still asserted) when it and all higher digits are 0; units digit always shown;
//   no effect when overflow=1.
//  Not defined: all digits always decoded, leading zeros display 7'b0111111.
// TESTING  (WIDTH=8, DIGITS=3, SCAN_DIV=4 unless stated)
//  1 rst=1 2 cycles, release, enable=1 -> ready=1, overflow=0, seg=0111111 each slot,
//    digit_sel sequence 001,010,100 each held 4 cycles.
//  2 load=1 value=123 one cycle -> ready=0 for 8 cycles; then digit_sel 001/010/100
//    shows 1001111/1011011/0000110.
//  3 load 255, then load 42 on cycle 3 of conversion -> second load ignored; display
//    255 (1101101,1101101,1011011), ready returns high after 8 cycles.
//  4 DIGITS=2: load 100 -> overflow=1, both digits 1000000; load 99 -> overflow=0, 1101111 x2.
//  5 load 7 -> with SSDEC_MUX_LZB_EN tens/hundreds seg=0, units 0000111; without, 0111111.
//  6 enable=0 mid-scan -> next cycle seg=0, digit_sel=0; rst asserted mid-conversion of
//    200 -> next cycle ready=1, display all zeros, overflow=0.

Source files
------------

// File: rtl/ssdec_mux_if.sv
// Display-path bundle between the stopwatch core and the seven-segment driver.
// The core (master) supplies value/load/enable; the driver (slave) returns status and the scan bus.
interface ssdec_mux_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic              enable;
    logic              load;
    logic [WIDTH-1:0]  value;
    logic              ready;
    logic              overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] digit_sel;

    modport master (
        output enable, load, value,
        input  ready, overflow, seg, digit_sel
    );

    modport slave (
        input  enable, load, value,
        output ready, overflow, seg, digit_sel
    );
endinterface

// File: rtl/ssdec_mux.sv
// Multi-digit seven-segment driver: sequential shift-add-3 binary-to-BCD converter feeding a
// time-multiplexed digit scanner. Define SSDEC_MUX_LZB_EN to blank leading zeros.
module ssdec_mux #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    ssdec_mux_if.slave bus
);
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    localparam int          BCD_W    = 4 * DIGITS;
    localparam int          CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int          DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] LIMIT    = pow10(DIGITS);
    localparam logic [6:0]  SEG_DASH = 7'b1000000;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t state_q, state_d;
    logic   conv_ready;

    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              overflow_q, overflow_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;

    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  work_shift;
    logic              last_iter;
    logic              div_wrap;
    logic [6:0]        dig_seg [DIGITS];
    logic [DIGITS-1:0] blank;

    // ---------------- FSM: state register / next state / outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.load) state_d = S_CONV;
            S_CONV:  if (last_iter) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        conv_ready = (state_q == S_IDLE);
    end

    // ---------------- shift-add-3 datapath ----------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ? (work_q[4*gi +: 4] + 4'd3)
                                                            : work_q[4*gi +: 4];
    end

    // The top adjusted bit falls off the register: only matters for values that overflow anyway.
    assign work_shift = BCD_W'({adj, bin_q[WIDTH-1]});
    assign last_iter  = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        bin_d      = bin_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        if (conv_ready) begin
            if (bus.load) begin
                bin_d      = bus.value;
                work_d     = '0;
                cnt_d      = '0;
                ovf_pend_d = (64'(bus.value) >= LIMIT);
            end
        end else begin
            bin_d  = bin_q << 1;
            work_d = work_shift;
            cnt_d  = cnt_q + 1'b1;
            if (last_iter) begin
                bcd_d      = work_shift;
                overflow_d = ovf_pend_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- per-digit decode ----------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        logic [3:0] nib;
        assign nib = bcd_q[4*gi +: 4];
`ifdef SSDEC_MUX_LZB_EN
        if (gi == 0) begin : g_units
            assign blank[gi] = 1'b0;
        end else begin : g_upper
            assign blank[gi] = (bcd_q[BCD_W-1:4*gi] == '0);
        end
`else
        assign blank[gi] = 1'b0;
`endif
        assign dig_seg[gi] = overflow_q ? SEG_DASH : (blank[gi] ? 7'b0000000 : decode(nib));
    end

    // ---------------- scan divider and registered outputs ----------------
    assign div_wrap = (div_q == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        div_d = div_wrap ? '0 : (div_q + 1'b1);
        idx_d = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : (idx_q + 1'b1);
        end
    end

    always_comb begin
        seg_d = 7'b0000000;
        sel_d = '0;
        if (bus.enable) begin
            sel_d = DIGITS'(1) << idx_q;
            seg_d = dig_seg[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= 7'b0000000;
            sel_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            sel_q <= sel_d;
        end
    end

    assign bus.ready     = conv_ready;
    assign bus.overflow  = overflow_q;
    assign bus.seg       = seg_q;
    assign bus.digit_sel = sel_q;

endmodule
